rw_strobe_gen: RTL and testbench

//  Initiator side of the RW/RD strobe interface. Turns a one-cycle request into one

---
 rtl/rw_strobe_pkg.sv | 21 ++
 rtl/strobe_down_cnt.sv | 27 ++
 rtl/rw_strobe_gen.sv | 123 ++++++++++++
 tb/tb_rw_strobe_gen.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/rw_strobe_pkg.sv
// Shared types and constants for the RW/RD strobe initiator.
package rw_strobe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } strobe_state_t;

    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_PULSE_CYC = 4;
    localparam int unsigned DEF_HOLD_CYC  = 2;
    localparam int unsigned DEF_CNT_W     = 8;

    // A phase length is usable when it is at least one cycle and its count-1 fits the counter.
    function automatic bit phase_len_ok(input int unsigned cyc, input int unsigned cnt_w);
        return (cyc >= 1) && (64'(cyc) <= (64'(1) << cnt_w));
    endfunction

endpackage

// File: rtl/strobe_down_cnt.sv
// Loadable down-counter with a zero flag; saturates at zero instead of wrapping.
module strobe_down_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/rw_strobe_gen.sv
// RW/RD strobe initiator: one request becomes a SETUP / PULSE / HOLD framed strobe.
module rw_strobe_gen
    import rw_strobe_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic CLK,
    input  logic CLR,
    input  logic req,
    input  logic req_rd,
    output logic strob_RW_RD,
    output logic rd_nwr,
    output logic busy,
    output logic done,
    output logic overrun
);

    if (!phase_len_ok(SETUP_CYC, CNT_W) || !phase_len_ok(PULSE_CYC, CNT_W) ||
        !phase_len_ok(HOLD_CYC, CNT_W)) begin : g_bad_cfg
        $error("rw_strobe_gen: phase lengths must be in 1..2**CNT_W");
    end

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(HOLD_CYC - 1);

    strobe_state_t    r_state;
    strobe_state_t    w_state_nxt;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_dec;
    logic             w_zero;
    logic             r_strob;
    logic             r_rd_nwr;
    logic             r_busy;
    logic             r_done;
    logic             r_overrun;

    strobe_down_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .i_clk      (CLK),
        .i_clr      (CLR),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    // Each phase loads its length-1 on entry and is left once the counter reads zero.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_dec       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (req) begin
                    w_state_nxt = SETUP;
                    w_load      = 1'b1;
                    w_load_val  = LD_SETUP;
                end
            end
            SETUP: begin
                if (w_zero) begin
                    w_state_nxt = PULSE;
                    w_load      = 1'b1;
                    w_load_val  = LD_PULSE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            PULSE: begin
                if (w_zero) begin
                    w_state_nxt = HOLD;
                    w_load      = 1'b1;
                    w_load_val  = LD_HOLD;
                end else begin
                    w_dec = 1'b1;
                end
            end
            HOLD: begin
                if (w_zero) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_dec = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state   <= IDLE;
            r_strob   <= 1'b0;
            r_rd_nwr  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_strob   <= (w_state_nxt == PULSE);
            r_busy    <= (w_state_nxt != IDLE);
            r_done    <= (r_state == HOLD) && w_zero;
            r_overrun <= req && (r_state != IDLE);
            if ((r_state == IDLE) && req) begin
                r_rd_nwr <= req_rd;
            end
        end
    end

    assign strob_RW_RD = r_strob;
    assign rd_nwr      = r_rd_nwr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_rw_strobe_gen.sv
// Directed-vector bench for rw_strobe_gen, plus a parameter sweep over eight instances.
module tb_rw_strobe_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic CLR, req, req_rd;
    logic strob_RW_RD, rd_nwr, busy, done, overrun;

    rw_strobe_gen dut (
        .CLK         (clk),
        .CLR         (CLR),
        .req         (req),
        .req_rd      (req_rd),
        .strob_RW_RD (strob_RW_RD),
        .rd_nwr      (rd_nwr),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun)
    );

    // Sweep table: SETUP x PULSE x HOLD over {1,3} x {1,5} x {1,2}.
    localparam int SW_S [8] = '{1, 1, 1, 1, 3, 3, 3, 3};
    localparam int SW_P [8] = '{1, 1, 5, 5, 1, 1, 5, 5};
    localparam int SW_H [8] = '{1, 2, 1, 2, 1, 2, 1, 2};

    logic       sw_clr, sw_req, sw_rd;
    logic [7:0] sw_strb, sw_rdn, sw_busy, sw_done, sw_ovr;

    for (genvar gi = 0; gi < 8; gi++) begin : g_sw
        rw_strobe_gen #(
            .SETUP_CYC (SW_S[gi]),
            .PULSE_CYC (SW_P[gi]),
            .HOLD_CYC  (SW_H[gi]),
            .CNT_W     (8)
        ) u_sw (
            .CLK         (clk),
            .CLR         (sw_clr),
            .req         (sw_req),
            .req_rd      (sw_rd),
            .strob_RW_RD (sw_strb[gi]),
            .rd_nwr      (sw_rdn[gi]),
            .busy        (sw_busy[gi]),
            .done        (sw_done[gi]),
            .overrun     (sw_ovr[gi])
        );
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] bit1(input int k);
        logic [31:0] m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    // Masks are indexed by cycle; cycle 0 is the first cycle after a one-cycle reset.
    task automatic run_case(input string nm,
                            input logic [31:0] reqm, input logic [31:0] rdm,
                            input logic [31:0] clrm,
                            input logic [31:0] e_busy, input logic [31:0] e_strb,
                            input logic [31:0] e_done, input logic [31:0] e_ovr,
                            input logic [31:0] e_rd);
        CLR = 1'b1; req = 1'b0; req_rd = 1'b0;
        tick();
        CLR = 1'b0;
        for (int c = 0; c < 32; c++) begin
            chk($sformatf("%s.busy@%0d", nm, c), 32'(busy), 32'(e_busy[c]));
            chk($sformatf("%s.strobe@%0d", nm, c), 32'(strob_RW_RD), 32'(e_strb[c]));
            chk($sformatf("%s.done@%0d", nm, c), 32'(done), 32'(e_done[c]));
            chk($sformatf("%s.overrun@%0d", nm, c), 32'(overrun), 32'(e_ovr[c]));
            chk($sformatf("%s.rd_nwr@%0d", nm, c), 32'(rd_nwr), 32'(e_rd[c]));
            req    = reqm[c];
            req_rd = rdm[c];
            CLR    = clrm[c];
            tick();
        end
        CLR = 1'b0; req = 1'b0;
    endtask

    int bsy_n [8];
    int stb_n [8];
    int rise_n[8];
    int done_n[8];
    int done_c[8];
    int ovr_n [8];

    initial begin
        sw_clr = 1'b1; sw_req = 1'b0; sw_rd = 1'b1;

        // Reset held with req asserted: nothing may start.
        CLR = 1'b1; req = 1'b1; req_rd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("rst.strobe@%0d", c), 32'(strob_RW_RD), 32'd0);
            chk($sformatf("rst.busy@%0d", c), 32'(busy), 32'd0);
            chk($sformatf("rst.done@%0d", c), 32'(done), 32'd0);
            chk($sformatf("rst.overrun@%0d", c), 32'(overrun), 32'd0);
            chk($sformatf("rst.rd_nwr@%0d", c), 32'(rd_nwr), 32'd0);
        end
        CLR = 1'b0; req = 1'b0;

        run_case("read", bit1(10), bit1(10), '0,
                 rng(11, 18), rng(13, 16), bit1(19), '0, rng(11, 31));

        run_case("wr_ovr", bit1(10) | bit1(14), bit1(14), '0,
                 rng(11, 18), rng(13, 16), bit1(19), bit1(15), '0);

        run_case("b2b", bit1(10) | bit1(19), bit1(10), '0,
                 rng(11, 18) | rng(20, 27), rng(13, 16) | rng(22, 25),
                 bit1(19) | bit1(28), '0, rng(11, 19));

        run_case("abort", bit1(10) | bit1(20), bit1(10) | bit1(20), bit1(14),
                 rng(11, 14) | rng(21, 28), rng(13, 14) | rng(23, 26),
                 bit1(29), '0, rng(11, 14) | rng(21, 31));

        // Parameter sweep: one read request at cycle 2 on all instances.
        for (int i = 0; i < 8; i++) begin
            bsy_n[i] = 0; stb_n[i] = 0; rise_n[i] = 0;
            done_n[i] = 0; done_c[i] = -1; ovr_n[i] = 0;
        end
        sw_clr = 1'b1;
        tick();
        sw_clr = 1'b0;
        begin
            logic [7:0] prev_strb;
            prev_strb = '0;
            for (int c = 0; c < 24; c++) begin
                for (int i = 0; i < 8; i++) begin
                    if (sw_busy[i]) bsy_n[i]++;
                    if (sw_strb[i]) stb_n[i]++;
                    if (sw_strb[i] && !prev_strb[i]) rise_n[i]++;
                    if (sw_done[i]) begin
                        done_n[i]++;
                        done_c[i] = c;
                    end
                    if (sw_ovr[i]) ovr_n[i]++;
                end
                prev_strb = sw_strb;
                sw_req = (c == 2);
                tick();
            end
        end
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("sw%0d.strobe_width", i), 32'(stb_n[i]), 32'(SW_P[i]));
            chk($sformatf("sw%0d.strobe_rises", i), 32'(rise_n[i]), 32'd1);
            chk($sformatf("sw%0d.busy_len", i), 32'(bsy_n[i]), 32'(SW_S[i] + SW_P[i] + SW_H[i]));
            chk($sformatf("sw%0d.done_latency", i), 32'(done_c[i] - 2),
                32'(SW_S[i] + SW_P[i] + SW_H[i] + 1));
            chk($sformatf("sw%0d.done_count", i), 32'(done_n[i]), 32'd1);
            chk($sformatf("sw%0d.overrun", i), 32'(ovr_n[i]), 32'd0);
            chk($sformatf("sw%0d.rd_nwr", i), 32'(sw_rdn[i]), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
